frame_lookup_ctrl: RTL and testbench

FRAME_LOOKUP_CTRL -- requirements
Module: frame_lookup_ctrl

---
 rtl/frame_lookup_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_frame_lookup_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_lookup_ctrl.sv
// ---------------------------------------------------------------------------
// frame_lookup_ctrl
//
// Purpose:
//   Header-capture and forwarding-decision controller for an L2 switch.
//   It collects the first 12 bytes of each ingress frame (DA then SA).
//   Using the source address, it issues a learn request to the address
//   table. For unicast destinations it issues a lookup and waits a bounded
//   time for the answer. It then presents an egress port mask, which is
//   held until the consumer accepts it.
//
// Parameters:
//   NUM_PORTS     number of switch ports (PW = $clog2(NUM_PORTS))
//   RESP_TIMEOUT  cycles to wait for a table response before flooding
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   rx_data_i/valid_i/sof_i/port_i  ingress byte stream (first byte DA[47:40])
//   rx_ready_o                      header bytes are accepted
//   learn_req_o/address_o/port_o    table learn interface (SA, ingress port)
//   read_req_o/address_o            table lookup interface (DA)
//   read_port_i/read_port_valid_i   table lookup response
//   fwd_valid_o/mask_o/ready_i      forwarding decision handshake
//
// Optional feature (macro FWD_STATS_EN):
//   stat_hit_o, stat_miss_o, stat_flood_o -- 16-bit saturating counters of
//   table hits, lookup timeouts and multicast floods.
// ---------------------------------------------------------------------------
module frame_lookup_ctrl #(
    parameter int NUM_PORTS    = 4,
    parameter int RESP_TIMEOUT = 4,
    localparam int PW          = $clog2(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           rx_data_i,
    input  logic                 rx_valid_i,
    input  logic                 rx_sof_i,
    input  logic [PW-1:0]        rx_port_i,
    output logic                 rx_ready_o,
    output logic                 learn_req_o,
    output logic [47:0]          learn_address_o,
    output logic [PW-1:0]        learn_port_o,
    output logic                 read_req_o,
    output logic [47:0]          read_address_o,
    input  logic [PW-1:0]        read_port_i,
    input  logic                 read_port_valid_i,
    output logic                 fwd_valid_o,
    output logic [NUM_PORTS-1:0] fwd_mask_o,
    input  logic                 fwd_ready_i
`ifdef FWD_STATS_EN
    ,
    output logic [15:0]          stat_hit_o,
    output logic [15:0]          stat_miss_o,
    output logic [15:0]          stat_flood_o
`endif
);

    // Response counter sized to hold 0 .. RESP_TIMEOUT-1.
    localparam int CW = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
    localparam logic [CW-1:0] RESP_LAST = CW'(RESP_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        REQ,
        WAIT,
        DECIDE
    } state_t;

    state_t               state;
    state_t               next_state;

    // hdr[95:48] = DA, hdr[47:0] = SA once all 12 bytes have shifted in.
    logic [95:0]          hdr;
    logic [3:0]           byte_cnt;
    logic [PW-1:0]        ingress;
    logic [CW-1:0]        resp_cnt;
    logic [NUM_PORTS-1:0] mask;

    logic [47:0]          da;
    logic [47:0]          sa;
    logic                 hit_evt;
    logic                 miss_evt;
    logic                 flood_evt;
    logic [NUM_PORTS-1:0] ingress_oh;
    logic [NUM_PORTS-1:0] resp_oh;
    logic [NUM_PORTS-1:0] flood_mask;
    logic [NUM_PORTS-1:0] hit_mask;

    assign da              = hdr[95:48];
    assign sa              = hdr[47:0];
    assign learn_address_o = sa;
    assign read_address_o  = da;
    assign learn_port_o    = ingress;
    assign fwd_mask_o      = mask;

    // One-hot decode of the ingress port and of the table answer. A table
    // answer that names a port >= NUM_PORTS matches no bit and so decodes to
    // an all-zero mask. Removing the ingress bit from the hit mask makes a
    // frame destined back to its own port a filtered (mask = 0) decision.
    always_comb begin
        ingress_oh = '0;
        resp_oh    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            ingress_oh[i] = (ingress == PW'(i));
            resp_oh[i]    = (read_port_i == PW'(i));
        end
    end

    assign flood_mask = ~ingress_oh;
    assign hit_mask   = resp_oh & ~ingress_oh;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and Moore outputs.
    // The learn and read strobes are decoded from the single-cycle REQ state,
    // so each one can only ever last one cycle. When both apply, they fire
    // together. The hit/miss/flood events mark the cycle that enters DECIDE
    // and choose which mask gets loaded.
    always_comb begin
        next_state  = state;
        rx_ready_o  = 1'b0;
        learn_req_o = 1'b0;
        read_req_o  = 1'b0;
        fwd_valid_o = 1'b0;
        hit_evt     = 1'b0;
        miss_evt    = 1'b0;
        flood_evt   = 1'b0;
        case (state)
            IDLE: begin
                rx_ready_o = 1'b1;
                if (rx_valid_i && rx_sof_i) begin
                    next_state = HDR;
                end
            end
            HDR: begin
                rx_ready_o = 1'b1;
                if (rx_valid_i && !rx_sof_i && (byte_cnt == 4'd11)) begin
                    next_state = REQ;
                end
            end
            REQ: begin
                learn_req_o = ~sa[40];
                read_req_o  = ~da[40];
                if (da[40]) begin
                    flood_evt  = 1'b1;
                    next_state = DECIDE;
                end else begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (read_port_valid_i) begin
                    hit_evt    = 1'b1;
                    next_state = DECIDE;
                end else if (resp_cnt == RESP_LAST) begin
                    miss_evt   = 1'b1;
                    next_state = DECIDE;
                end
            end
            DECIDE: begin
                fwd_valid_o = 1'b1;
                if (fwd_ready_i) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Header capture.
    // A start-of-frame byte always restarts capture: it clears the partial
    // header and re-latches the ingress port, whether the block is in IDLE
    // or in the middle of a header. Bytes offered while rx_ready_o is low
    // are dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hdr      <= '0;
            byte_cnt <= '0;
            ingress  <= '0;
        end else if (rx_valid_i && rx_ready_o) begin
            if (rx_sof_i) begin
                hdr      <= {88'd0, rx_data_i};
                byte_cnt <= 4'd1;
                ingress  <= rx_port_i;
            end else if (state == HDR) begin
                hdr      <= {hdr[87:0], rx_data_i};
                byte_cnt <= byte_cnt + 4'd1;
            end
        end
    end

    // Response timer and decision mask.
    // The timer restarts in REQ and counts WAIT cycles. The mask register
    // holds its value through DECIDE, so fwd_mask_o stays stable until the
    // handshake completes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_cnt <= '0;
            mask     <= '0;
        end else begin
            if (state == REQ) begin
                resp_cnt <= '0;
            end else if (state == WAIT) begin
                resp_cnt <= resp_cnt + CNT_ONE;
            end
            if (flood_evt || miss_evt) begin
                mask <= flood_mask;
            end else if (hit_evt) begin
                mask <= hit_mask;
            end
        end
    end

`ifdef FWD_STATS_EN
    // Decision statistics. Each counter saturates at all-ones rather than
    // wrapping, so a long run never makes a busy counter look idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_hit_o   <= '0;
            stat_miss_o  <= '0;
            stat_flood_o <= '0;
        end else begin
            if (hit_evt && (stat_hit_o != 16'hFFFF)) begin
                stat_hit_o <= stat_hit_o + 16'd1;
            end
            if (miss_evt && (stat_miss_o != 16'hFFFF)) begin
                stat_miss_o <= stat_miss_o + 16'd1;
            end
            if (flood_evt && (stat_flood_o != 16'hFFFF)) begin
                stat_flood_o <= stat_flood_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_frame_lookup_ctrl.sv
// ---------------------------------------------------------------------------
// tb_frame_lookup_ctrl
//
// Directed-vector bench for frame_lookup_ctrl. It uses the default
// parameters (NUM_PORTS=4, RESP_TIMEOUT=4). All expected values are
// hand-computed constants. Inputs are driven, and outputs sampled, 1 ns
// after each rising clock edge.
// ---------------------------------------------------------------------------
module tb_frame_lookup_ctrl;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_sof_i;
    logic [1:0]  rx_port_i;
    logic        rx_ready_o;
    logic        learn_req_o;
    logic [47:0] learn_address_o;
    logic [1:0]  learn_port_o;
    logic        read_req_o;
    logic [47:0] read_address_o;
    logic [1:0]  read_port_i;
    logic        read_port_valid_i;
    logic        fwd_valid_o;
    logic [3:0]  fwd_mask_o;
    logic        fwd_ready_i;
`ifdef FWD_STATS_EN
    logic [15:0] stat_hit_o;
    logic [15:0] stat_miss_o;
    logic [15:0] stat_flood_o;
`endif

    int checks   = 0;
    int failures = 0;

    frame_lookup_ctrl #(
        .NUM_PORTS    (4),
        .RESP_TIMEOUT (4)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .rx_data_i         (rx_data_i),
        .rx_valid_i        (rx_valid_i),
        .rx_sof_i          (rx_sof_i),
        .rx_port_i         (rx_port_i),
        .rx_ready_o        (rx_ready_o),
        .learn_req_o       (learn_req_o),
        .learn_address_o   (learn_address_o),
        .learn_port_o      (learn_port_o),
        .read_req_o        (read_req_o),
        .read_address_o    (read_address_o),
        .read_port_i       (read_port_i),
        .read_port_valid_i (read_port_valid_i),
        .fwd_valid_o       (fwd_valid_o),
        .fwd_mask_o        (fwd_mask_o),
        .fwd_ready_i       (fwd_ready_i)
`ifdef FWD_STATS_EN
        ,
        .stat_hit_o        (stat_hit_o),
        .stat_miss_o       (stat_miss_o),
        .stat_flood_o      (stat_flood_o)
`endif
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Present one byte and advance to 1 ns past the edge that samples it.
    task automatic applyStimulus(input logic [7:0] data, input logic sof,
                                 input logic [1:0] port);
        rx_data_i  = data;
        rx_valid_i = 1'b1;
        rx_sof_i   = sof;
        rx_port_i  = port;
        @(posedge clk);
        #1;
    endtask

    // Send the first nbytes of the header {da, sa}, with SOF on byte 0.
    // After a full 12-byte header, the bench sits in the REQ cycle.
    task automatic sendHeader(input logic [1:0] port, input logic [47:0] da,
                              input logic [47:0] sa, input int nbytes);
        logic [95:0] h;
        h = {da, sa};
        for (int i = 0; i < nbytes; i++) begin
            applyStimulus(h[95-8*i -: 8], (i == 0), port);
        end
        rx_valid_i = 1'b0;
        rx_sof_i   = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic handshake(input string tag);
        fwd_ready_i = 1'b1;
        tick();
        fwd_ready_i = 1'b0;
        checkOutput({tag, "_valid_after_hs"}, 64'(fwd_valid_o), 64'd0);
        checkOutput({tag, "_ready_after_hs"}, 64'(rx_ready_o), 64'd1);
    endtask

    initial begin
        rst_n             = 1'b0;
        rx_data_i         = 8'h00;
        rx_valid_i        = 1'b0;
        rx_sof_i          = 1'b0;
        rx_port_i         = 2'd0;
        read_port_i       = 2'd0;
        read_port_valid_i = 1'b0;
        fwd_ready_i       = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        checkOutput("rst_rx_ready", 64'(rx_ready_o), 64'd1);
        checkOutput("rst_learn_req", 64'(learn_req_o), 64'd0);
        checkOutput("rst_read_req", 64'(read_req_o), 64'd0);
        checkOutput("rst_fwd_valid", 64'(fwd_valid_o), 64'd0);
        checkOutput("rst_fwd_mask", 64'(fwd_mask_o), 64'd0);
        checkOutput("rst_learn_addr", 64'(learn_address_o), 64'd0);
        checkOutput("rst_read_addr", 64'(read_address_o), 64'd0);
        checkOutput("rst_learn_port", 64'(learn_port_o), 64'd0);
        rst_n = 1'b1;
        tick();

        // Unicast hit: SA ..01 on port 1, DA ..02, table answers port 3
        sendHeader(2'd1, 48'h020000000002, 48'h020000000001, 12);
        checkOutput("t1_learn_req", 64'(learn_req_o), 64'd1);
        checkOutput("t1_learn_addr", 64'(learn_address_o), 64'h020000000001);
        checkOutput("t1_learn_port", 64'(learn_port_o), 64'd1);
        checkOutput("t1_read_req", 64'(read_req_o), 64'd1);
        checkOutput("t1_read_addr", 64'(read_address_o), 64'h020000000002);
        checkOutput("t1_rx_ready_req", 64'(rx_ready_o), 64'd0);
        tick();
        checkOutput("t1_learn_one_cycle", 64'(learn_req_o), 64'd0);
        checkOutput("t1_read_one_cycle", 64'(read_req_o), 64'd0);
        checkOutput("t1_valid_in_wait", 64'(fwd_valid_o), 64'd0);
        read_port_valid_i = 1'b1;
        read_port_i       = 2'd3;
        tick();
        read_port_valid_i = 1'b0;
        checkOutput("t1_fwd_valid", 64'(fwd_valid_o), 64'd1);
        checkOutput("t1_fwd_mask", 64'(fwd_mask_o), 64'h8);
        tick();
        tick();
        checkOutput("t1_valid_held", 64'(fwd_valid_o), 64'd1);
        checkOutput("t1_mask_held", 64'(fwd_mask_o), 64'h8);
        handshake("t1");

        // Broadcast DA on port 2: no lookup, flood to all but port 2
        sendHeader(2'd2, 48'hFFFFFFFFFFFF, 48'h020000000005, 12);
        checkOutput("t2_read_req", 64'(read_req_o), 64'd0);
        checkOutput("t2_learn_req", 64'(learn_req_o), 64'd1);
        checkOutput("t2_learn_port", 64'(learn_port_o), 64'd2);
        checkOutput("t2_valid_early", 64'(fwd_valid_o), 64'd0);
        tick();
        checkOutput("t2_fwd_valid", 64'(fwd_valid_o), 64'd1);
        checkOutput("t2_fwd_mask", 64'(fwd_mask_o), 64'hB);
        handshake("t2");

        // Lookup timeout from port 0; junk bytes offered while busy are ignored
        sendHeader(2'd0, 48'h020000000002, 48'h020000000003, 12);
        checkOutput("t3_read_req", 64'(read_req_o), 64'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            rx_data_i  = 8'hFF;
            rx_valid_i = 1'b1;
            rx_sof_i   = 1'b1;
            rx_port_i  = 2'd2;
            checkOutput("t3_wait_valid", 64'(fwd_valid_o), 64'd0);
            checkOutput("t3_wait_ready", 64'(rx_ready_o), 64'd0);
        end
        tick();
        rx_valid_i = 1'b0;
        rx_sof_i   = 1'b0;
        checkOutput("t3_fwd_valid", 64'(fwd_valid_o), 64'd1);
        checkOutput("t3_fwd_mask", 64'(fwd_mask_o), 64'hE);
        handshake("t3");

        // Table answers the ingress port: filtered decision, mask 0
        sendHeader(2'd1, 48'h020000000007, 48'h020000000008, 12);
        tick();
        read_port_valid_i = 1'b1;
        read_port_i       = 2'd1;
        tick();
        read_port_valid_i = 1'b0;
        checkOutput("t4_fwd_valid", 64'(fwd_valid_o), 64'd1);
        checkOutput("t4_fwd_mask", 64'(fwd_mask_o), 64'h0);
        handshake("t4");

        // Restart: 7 bytes of a broadcast frame on port 0, then SOF on port 3
        sendHeader(2'd0, 48'hFFFFFFFFFFFF, 48'h02000000000C, 7);
        checkOutput("t5_ready_mid_hdr", 64'(rx_ready_o), 64'd1);
        sendHeader(2'd3, 48'h02000000000A, 48'h02000000000B, 12);
        checkOutput("t5_learn_port", 64'(learn_port_o), 64'd3);
        checkOutput("t5_learn_addr", 64'(learn_address_o), 64'h02000000000B);
        checkOutput("t5_read_req", 64'(read_req_o), 64'd1);
        checkOutput("t5_read_addr", 64'(read_address_o), 64'h02000000000A);
        tick();
        read_port_valid_i = 1'b1;
        read_port_i       = 2'd0;
        tick();
        read_port_valid_i = 1'b0;
        checkOutput("t5_fwd_mask", 64'(fwd_mask_o), 64'h1);
        handshake("t5");

        // Multicast SA is not learned; unicast DA hit to port 2
        sendHeader(2'd3, 48'h020000000009, 48'h01005E000001, 12);
        checkOutput("t6_learn_req", 64'(learn_req_o), 64'd0);
        checkOutput("t6_read_req", 64'(read_req_o), 64'd1);
        tick();
        read_port_valid_i = 1'b1;
        read_port_i       = 2'd2;
        tick();
        read_port_valid_i = 1'b0;
        checkOutput("t6_fwd_mask", 64'(fwd_mask_o), 64'h4);
        handshake("t6");

        // Consumer stalls 10 cycles, then reset abandons the decision
        sendHeader(2'd0, 48'hFFFFFFFFFFFF, 48'h020000000006, 12);
        tick();
        checkOutput("t7_fwd_mask", 64'(fwd_mask_o), 64'hE);
`ifdef FWD_STATS_EN
        checkOutput("t7_stat_hit", 64'(stat_hit_o), 64'd4);
        checkOutput("t7_stat_miss", 64'(stat_miss_o), 64'd1);
        checkOutput("t7_stat_flood", 64'(stat_flood_o), 64'd2);
`endif
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("t7_valid_stall", 64'(fwd_valid_o), 64'd1);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("t7_valid_after_rst", 64'(fwd_valid_o), 64'd0);
        checkOutput("t7_ready_after_rst", 64'(rx_ready_o), 64'd1);
        checkOutput("t7_mask_after_rst", 64'(fwd_mask_o), 64'd0);
        checkOutput("t7_addr_after_rst", 64'(learn_address_o), 64'd0);
`ifdef FWD_STATS_EN
        checkOutput("t7_stat_hit_rst", 64'(stat_hit_o), 64'd0);
        checkOutput("t7_stat_miss_rst", 64'(stat_miss_o), 64'd0);
        checkOutput("t7_stat_flood_rst", 64'(stat_flood_o), 64'd0);
`endif
        tick();
        checkOutput("t7_valid_stays_low", 64'(fwd_valid_o), 64'd0);

        // Reset while waiting on the table leaves nothing pending
        sendHeader(2'd1, 48'h020000000004, 48'h020000000001, 12);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("t8_read_req", 64'(read_req_o), 64'd0);
        checkOutput("t8_ready", 64'(rx_ready_o), 64'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput("t8_no_decision", 64'(fwd_valid_o), 64'd0);
            checkOutput("t8_no_learn", 64'(learn_req_o), 64'd0);
        end

        // Recovery: a fresh broadcast frame still works after the abort
        sendHeader(2'd3, 48'hFFFFFFFFFFFF, 48'h020000000002, 12);
        tick();
        checkOutput("t9_fwd_valid", 64'(fwd_valid_o), 64'd1);
        checkOutput("t9_fwd_mask", 64'(fwd_mask_o), 64'h7);
        handshake("t9");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
